// File: rtl/laser_pkg.sv
// Shared encodings and sizing for the push-button conditioner feeding the laser FSM.
package laser_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int PRESS_COUNT_W           = 8;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [PRESS_COUNT_W-1:0] sat_inc(input logic [PRESS_COUNT_W-1:0] v);
    logic [PRESS_COUNT_W-1:0] r;
    if (v == {PRESS_COUNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + PRESS_COUNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous button level; clears to 0 on reset.
module btn_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces a bouncing push-button and issues one B pulse per accepted press,
// or a Rejected pulse instead when the laser is already firing.
module button_pulse_conditioner
  import laser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     BtnRaw,
  input  logic                     LaserBusy,
  output logic                     B,
  output logic                     Rejected,
  output logic                     Debounced,
  output logic [PRESS_COUNT_W-1:0] PressCount,
  output logic [1:0]               State
);

  // Wide enough to hold DEBOUNCE_CYCLES itself; the count tops out there, so it never wraps.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic                     sync_s;
  btn_state_t               state_r;
  btn_state_t               state_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_s;
  logic                     accept_s;
  logic                     b_r;
  logic                     rej_r;
  logic                     debounced_r;
  logic [PRESS_COUNT_W-1:0] press_cnt_r;

  btn_sync u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .d   (BtnRaw),
    .q   (sync_s)
  );

  // Next-state and stability-counter logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        if (sync_s) begin
          state_s = ST_PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_RELEASED;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_s) begin
          state_s = ST_RELEASED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s  = ST_HELD;
          cnt_s    = CNT_ZERO;
          accept_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync_s) begin
          state_s = ST_RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_s) begin
          state_s = ST_HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s = ST_RELEASED;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_RELEASE_WAIT;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register; reset parks in RELEASE_WAIT so a button held through reset must be released first.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= ST_RELEASE_WAIT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered pulses and level; LaserBusy only matters on the acceptance edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      b_r         <= 1'b0;
      rej_r       <= 1'b0;
      debounced_r <= 1'b1;
      press_cnt_r <= {PRESS_COUNT_W{1'b0}};
    end else begin
      b_r         <= accept_s & ~LaserBusy;
      rej_r       <= accept_s & LaserBusy;
      debounced_r <= (state_s == ST_HELD) || (state_s == ST_RELEASE_WAIT);
      if (accept_s && !LaserBusy) begin
        press_cnt_r <= sat_inc(press_cnt_r);
      end else begin
        press_cnt_r <= press_cnt_r;
      end
    end
  end

  assign B          = b_r;
  assign Rejected   = rej_r;
  assign Debounced  = debounced_r;
  assign PressCount = press_cnt_r;
  assign State      = state_r;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_button_pulse_conditioner;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       BtnRaw;
  logic       LaserBusy;
  logic       B;
  logic       Rejected;
  logic       Debounced;
  logic [7:0] PressCount;
  logic [1:0] State;

  int total = 0;
  int bad   = 0;
  int b_cnt = 0;
  int rej_cnt = 0;
  int both_cnt = 0;

  button_pulse_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .BtnRaw     (BtnRaw),
    .LaserBusy  (LaserBusy),
    .B          (B),
    .Rejected   (Rejected),
    .Debounced  (Debounced),
    .PressCount (PressCount),
    .State      (State)
  );

  always #5 Clk = ~Clk;

  // Pulse bookkeeping on the falling edge, away from output updates.
  always @(negedge Clk) begin
    if (B) b_cnt++;
    if (Rejected) rej_cnt++;
    if (B && Rejected) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; BtnRaw = 1'b0; LaserBusy = 1'b0;
    step(2);
    check_val("rst_state", State, 32'd3);
    check_val("rst_b", B, 32'd0);
    check_val("rst_rej", Rejected, 32'd0);
    check_val("rst_cnt", PressCount, 32'd0);
    check_val("rst_deb", Debounced, 32'd1);
    Rst = 1'b1;
    step(10);
    check_val("idle_state", State, 32'd0);
    check_val("idle_deb", Debounced, 32'd0);

    // Clean press: B appears after the 7th edge counting the capture edge.
    BtnRaw = 1'b1;
    step(6);
    check_val("clean_b_early", B, 32'd0);
    step(1);
    check_val("clean_b", B, 32'd1);
    check_val("clean_state", State, 32'd2);
    check_val("clean_deb", Debounced, 32'd1);
    step(1);
    check_val("clean_b_one", B, 32'd0);
    step(12);
    check_val("clean_cnt", PressCount, 32'd1);
    check_val("clean_bcnt", b_cnt, 32'd1);
    BtnRaw = 1'b0;
    step(10);
    check_val("rel_state", State, 32'd0);
    check_val("rel_deb", Debounced, 32'd0);

    // Bounce never reaches acceptance.
    BtnRaw = 1'b1; step(2);
    BtnRaw = 1'b0; step(1);
    BtnRaw = 1'b1; step(2);
    BtnRaw = 1'b0; step(10);
    check_val("bounce_bcnt", b_cnt, 32'd1);
    check_val("bounce_rej", rej_cnt, 32'd0);
    check_val("bounce_state", State, 32'd0);
    check_val("bounce_cnt", PressCount, 32'd1);

    // Busy laser: Rejected instead of B; dropping LaserBusy while held changes nothing.
    LaserBusy = 1'b1;
    BtnRaw = 1'b1;
    step(6);
    check_val("busy_rej_early", Rejected, 32'd0);
    step(1);
    check_val("busy_rej", Rejected, 32'd1);
    check_val("busy_b", B, 32'd0);
    step(1);
    check_val("busy_rej_one", Rejected, 32'd0);
    LaserBusy = 1'b0;
    step(12);
    check_val("busy_bcnt", b_cnt, 32'd1);
    check_val("busy_rejcnt", rej_cnt, 32'd1);
    check_val("busy_cnt", PressCount, 32'd1);
    BtnRaw = 1'b0;
    step(10);

    // Held through reset: no pulse until a real release and re-press.
    BtnRaw = 1'b1;
    step(20);
    check_val("held_bcnt", b_cnt, 32'd2);
    Rst = 1'b0; step(1); Rst = 1'b1;
    check_val("hrst_state", State, 32'd3);
    check_val("hrst_cnt", PressCount, 32'd0);
    check_val("hrst_deb", Debounced, 32'd1);
    step(20);
    check_val("hrst_held", State, 32'd2);
    check_val("hrst_nob", b_cnt, 32'd2);
    BtnRaw = 1'b0; step(2);
    BtnRaw = 1'b1; step(20);
    check_val("short_rel_nob", b_cnt, 32'd2);
    BtnRaw = 1'b0; step(10);
    check_val("hrst_rel", State, 32'd0);
    BtnRaw = 1'b1; step(20);
    check_val("repress_bcnt", b_cnt, 32'd3);
    check_val("repress_cnt", PressCount, 32'd1);
    BtnRaw = 1'b0; step(10);

    // Reset on the very edge that would accept suppresses the pulse.
    BtnRaw = 1'b1;
    step(6);
    Rst = 1'b0; step(1);
    check_val("rst_edge_b", B, 32'd0);
    check_val("rst_edge_state", State, 32'd3);
    Rst = 1'b1; BtnRaw = 1'b0;
    step(12);
    check_val("rst_edge_bcnt", b_cnt, 32'd3);
    check_val("rst_edge_idle", State, 32'd0);

    // Saturation over 260 press/release pairs.
    for (int i = 0; i < 260; i++) begin
      BtnRaw = 1'b1; step(8);
      BtnRaw = 1'b0; step(8);
      if (i == 253) check_val("sat_254", PressCount, 32'd254);
      if (i == 254) check_val("sat_255", PressCount, 32'd255);
    end
    check_val("sat_final", PressCount, 32'd255);
    check_val("sat_bcnt", b_cnt, 32'd263);
    check_val("never_both", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
